// File: rtl/bus_arbiter_mem_if.sv
// Shared-bus bundle between requesting cores and the bus_arbiter_mem target.
// Masters drive requests, direction, address and write data; the target returns grant and read data.
interface bus_arbiter_mem_if #(
    parameter int unsigned NUM_MASTERS = 2
);
    logic [NUM_MASTERS-1:0]    grant_request;
    logic [NUM_MASTERS-1:0]    rw;
    logic [NUM_MASTERS*10-1:0] address;
    logic [NUM_MASTERS*8-1:0]  data_out;
    logic [NUM_MASTERS-1:0]    grant_given;
    logic [7:0]                data_in;

    modport master (
        output grant_request,
        output rw,
        output address,
        output data_out,
        input  grant_given,
        input  data_in
    );

    modport slave (
        input  grant_request,
        input  rw,
        input  address,
        input  data_out,
        output grant_given,
        output data_in
    );
endinterface

// File: rtl/bus_arbiter_mem.sv
// Round-robin shared-bus target: byte RAM plus a small GPIO window, one transaction per 4 cycles.
// A separate program-load port can fill the RAM at any time, including during reset.
module bus_arbiter_mem #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned MEM_DEPTH   = 512,
    parameter int unsigned GPIO_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    bus_arbiter_mem_if.slave     bus,
    output logic [GPIO_W-1:0]    gpio_out,
    input  logic [GPIO_W-1:0]    gpio_in,
    input  logic                 prog_we,
    input  logic [8:0]           prog_addr,
    input  logic [7:0]           prog_data
);
    localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned AW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {StIdle, StAccess, StGrant, StCool} state_e;

    state_e                 state_q;
    logic [IW-1:0]          ptr_q;
    logic [IW-1:0]          sel_q;
    logic [IW-1:0]          win_idx;
    logic [IW-1:0]          cand;
    logic [IW-1:0]          ptr_next;
    logic                   win_valid;
    logic                   rw_q;
    logic [9:0]             addr_q;
    logic [7:0]             wdata_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [NUM_MASTERS-1:0] sel_onehot;
    logic [7:0]             data_in_q;
    logic [7:0]             access_data;
    logic [GPIO_W-1:0]      gpio_sync1_q;
    logic [GPIO_W-1:0]      gpio_sync2_q;
    logic                   ram_we;
    logic [7:0]             mem [MEM_DEPTH];

    assign bus.grant_given = grant_q;
    assign bus.data_in     = data_in_q;

    // Scan downward so the requester closest to the pointer is written last and wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr_q) + k) % NUM_MASTERS);
            if (bus.grant_request[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        ptr_next = (sel_q == IW'(NUM_MASTERS - 1)) ? '0 : sel_q + 1'b1;
    end

    always_comb begin
        sel_onehot        = '0;
        sel_onehot[sel_q] = 1'b1;
    end

    // Writes echo their own data so a store observes what it wrote.
    always_comb begin
        if (rw_q) begin
            access_data = wdata_q;
        end else if (!addr_q[9]) begin
            access_data = mem[addr_q[AW-1:0]];
        end else if (!addr_q[0]) begin
            access_data = 8'(gpio_out);
        end else begin
            access_data = 8'(gpio_sync2_q);
        end
    end

    assign ram_we = (state_q == StAccess) && !addr_q[9] && rw_q;

    // Bus write is issued last so it overrides a program-load write to the same byte.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr[AW-1:0]] <= prog_data;
        end
        if (ram_we) begin
            mem[addr_q[AW-1:0]] <= wdata_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_sync1_q <= '0;
            gpio_sync2_q <= '0;
        end else begin
            gpio_sync1_q <= gpio_in;
            gpio_sync2_q <= gpio_sync1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            sel_q     <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            grant_q   <= '0;
            data_in_q <= '0;
            gpio_out  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_valid) begin
                        sel_q   <= win_idx;
                        rw_q    <= bus.rw[win_idx];
                        addr_q  <= bus.address[win_idx*10 +: 10];
                        wdata_q <= bus.data_out[win_idx*8 +: 8];
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    if (addr_q[9] && rw_q && !addr_q[0]) begin
                        gpio_out <= wdata_q[GPIO_W-1:0];
                    end
                    grant_q   <= sel_onehot;
                    data_in_q <= access_data;
                    ptr_q     <= ptr_next;
                    state_q   <= StGrant;
                end
                StGrant: begin
                    grant_q   <= '0;
                    data_in_q <= '0;
                    state_q   <= StCool;
                end
                // The served master's request is still visible here, so do not arbitrate.
                StCool: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter_mem.sv
// Directed bench for bus_arbiter_mem: RAM, GPIO, round-robin, reset abort and program-load collision.
module tb_bus_arbiter_mem;
    localparam int unsigned N = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] gpio_out;
    logic [7:0] gpio_in;
    logic       prog_we;
    logic [8:0] prog_addr;
    logic [7:0] prog_data;
    int         checks = 0;
    int         errors = 0;

    bus_arbiter_mem_if #(.NUM_MASTERS(N)) bus ();

    bus_arbiter_mem #(
        .NUM_MASTERS(N),
        .MEM_DEPTH  (512),
        .GPIO_W     (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in),
        .prog_we  (prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_master(input int m, input logic w, input logic [9:0] a,
                              input logic [7:0] d);
        bus.rw[m]                = w;
        bus.address[m*10 +: 10]  = a;
        bus.data_out[m*8 +: 8]   = d;
    endtask

    task automatic prog(input logic [8:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    // Starts in an IDLE cycle, ends in the next IDLE cycle four clocks later.
    task automatic txn(input string tag, input int m, input logic w, input logic [9:0] a,
                       input logic [7:0] d, input logic [7:0] exp);
        set_master(m, w, a, d);
        bus.grant_request[m] = 1'b1;
        tick();
        check({tag, "_access_nogrant"}, 32'(bus.grant_given), 32'h0);
        tick();
        check({tag, "_grant"}, 32'(bus.grant_given), 32'(1 << m));
        check({tag, "_data"}, 32'(bus.data_in), 32'(exp));
        bus.grant_request[m] = 1'b0;
        tick();
        check({tag, "_cool"}, {22'h0, bus.grant_given, bus.data_in}, 32'h0);
        tick();
    endtask

    initial begin
        logic [1:0] exp_g;
        logic [7:0] exp_d;

        bus.grant_request = '0;
        bus.rw            = '0;
        bus.address       = '0;
        bus.data_out      = '0;
        gpio_in           = 8'h00;
        prog_we           = 1'b0;
        prog_addr         = '0;
        prog_data         = '0;

        // Program load during reset must still land in RAM.
        prog(9'h005, 8'hAA);
        tick();
        check("reset_grant", 32'(bus.grant_given), 32'h0);
        check("reset_data_in", 32'(bus.data_in), 32'h0);
        check("reset_gpio_out", 32'(gpio_out), 32'h0);
        reset = 1'b0;
        tick();

        txn("t1_read_005", 0, 1'b0, 10'h005, 8'h00, 8'hAA);

        txn("t2_write_1ff", 0, 1'b1, 10'h1FF, 8'h3C, 8'h3C);
        txn("t2_read_1ff", 0, 1'b0, 10'h1FF, 8'h00, 8'h3C);

        txn("t3_gpio_wr", 1, 1'b1, 10'h200, 8'h5A, 8'h5A);
        check("t3_gpio_out", 32'(gpio_out), 32'h5A);
        gpio_in = 8'h81;
        tick();
        tick();
        tick();
        txn("t3_gpio_in_rd", 1, 1'b0, 10'h201, 8'h00, 8'h81);
        txn("t3_gpio_in_wr", 1, 1'b1, 10'h201, 8'h00, 8'h00);
        check("t3_gpio_out_kept", 32'(gpio_out), 32'h5A);
        txn("t3_gpio_out_alias", 0, 1'b0, 10'h3FE, 8'h00, 8'h5A);

        // Reset lands during ACCESS of a write: no grant, no commit, gpio cleared.
        prog(9'h010, 8'h11);
        set_master(0, 1'b1, 10'h010, 8'h77);
        bus.grant_request[0] = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        check("t5_abort_grant_now", 32'(bus.grant_given), 32'h0);
        tick();
        check("t5_abort_grant_next", 32'(bus.grant_given), 32'h0);
        check("t5_abort_gpio_out", 32'(gpio_out), 32'h0);
        bus.grant_request[0] = 1'b0;
        reset = 1'b0;
        tick();
        txn("t5_read_010", 0, 1'b0, 10'h010, 8'h00, 8'h11);
        check("t5_gpio_out_after", 32'(gpio_out), 32'h0);

        // Both masters requesting continuously from a fresh reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_master(0, 1'b0, 10'h005, 8'h00);
        set_master(1, 1'b0, 10'h1FF, 8'h00);
        bus.grant_request = 2'b11;
        for (int t = 1; t <= 16; t++) begin
            tick();
            exp_g = (t == 2 || t == 10) ? 2'b01 : (t == 6 || t == 14) ? 2'b10 : 2'b00;
            exp_d = (t == 2 || t == 10) ? 8'hAA : (t == 6 || t == 14) ? 8'h3C : 8'h00;
            check($sformatf("t4_rr_grant_c%0d", t), 32'(bus.grant_given), 32'(exp_g));
            check($sformatf("t4_rr_data_c%0d", t), 32'(bus.data_in), 32'(exp_d));
            if (t == 15) bus.grant_request = '0;
        end

        // Same-address collision: the bus write wins; request and inputs change after IDLE.
        set_master(0, 1'b1, 10'h020, 8'h44);
        bus.grant_request[0] = 1'b1;
        tick();
        bus.grant_request[0] = 1'b0;
        set_master(0, 1'b0, 10'h3FF, 8'hEE);
        prog_we   = 1'b1;
        prog_addr = 9'h020;
        prog_data = 8'h99;
        tick();
        prog_we = 1'b0;
        check("t6_dropped_req_grant", 32'(bus.grant_given), 32'h1);
        check("t6_echo", 32'(bus.data_in), 32'h44);
        tick();
        tick();
        txn("t6_read_020", 0, 1'b0, 10'h020, 8'h00, 8'h44);

        // Different-address collision: both writes must commit.
        set_master(1, 1'b1, 10'h030, 8'h55);
        bus.grant_request[1] = 1'b1;
        tick();
        prog_we   = 1'b1;
        prog_addr = 9'h031;
        prog_data = 8'h66;
        tick();
        prog_we = 1'b0;
        bus.grant_request[1] = 1'b0;
        check("t6b_grant", 32'(bus.grant_given), 32'h2);
        tick();
        tick();
        txn("t6b_read_030", 1, 1'b0, 10'h030, 8'h00, 8'h55);
        txn("t6b_read_031", 0, 1'b0, 10'h031, 8'h00, 8'h66);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
